// File: rtl/bcd_cnt_pkg.sv
// Shared BCD constants, digit type and elaboration helpers for the multi-digit counter.
package bcd_cnt_pkg;

  localparam int BCD_W      = 4;
  localparam int MAX_DIGITS = 16;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic is_valid_bcd(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

  // Packs a decimal integer into BCD, digit 0 in bits [3:0]; wide enough for MAX_DIGITS.
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int val, input int n);
    logic [4*MAX_DIGITS-1:0] res;
    int v;
    res = '0;
    v   = val;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) begin
        res[4*i +: 4] = 4'(v % 10);
        v = v / 10;
      end
    end
    return res;
  endfunction

  function automatic longint pow10(input int n);
    longint p;
    p = 1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < n) p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One combinational BCD digit stage: steps up or down and propagates carry/borrow.
module bcd_digit_step
  import bcd_cnt_pkg::*;
(
  input  bcd_digit_t i_digit,
  input  logic       i_step_in,
  input  logic       i_up_down,
  output bcd_digit_t o_next_digit,
  output logic       o_step_out
);

  logic w_at_bound;

  assign w_at_bound = i_up_down ? (i_digit == BCD_MAX) : (i_digit == BCD_MIN);
  assign o_step_out = i_step_in & w_at_bound;

  always_comb begin
    o_next_digit = i_digit;
    if (i_step_in) begin
      if (w_at_bound) o_next_digit = i_up_down ? BCD_MIN : BCD_MAX;
      else            o_next_digit = i_up_down ? (i_digit + 4'd1) : (i_digit - 4'd1);
    end
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with enable, checked parallel load, cascade tc and wrap/error flags.
// Define BCD_UPDOWN_COUNTER_N_SATURATE_EN to saturate at the range ends instead of wrapping.
module bcd_updown_counter_n
  import bcd_cnt_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int RST_VAL  = 0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_count_en,
  input  logic                  i_up_down,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_load_val,
  output logic [4*N_DIGITS-1:0] o_bcd_out,
  output logic                  o_tc,
  output logic                  o_wrap,
  output logic                  o_load_err
);

  if (N_DIGITS < 1 || N_DIGITS > MAX_DIGITS || RST_VAL < 0 ||
      longint'(RST_VAL) >= pow10(N_DIGITS)) begin : g_bad_param
    $error("bcd_updown_counter_n: N_DIGITS or RST_VAL out of range");
  end

  localparam logic [4*MAX_DIGITS-1:0] RST_BCD_FULL = to_bcd(RST_VAL, N_DIGITS);
  localparam logic [4*N_DIGITS-1:0]   RST_BCD      = RST_BCD_FULL[4*N_DIGITS-1:0];

  logic [4*N_DIGITS-1:0] r_bcd;
  logic                  r_wrap;
  logic                  r_load_err;

  logic [N_DIGITS:0]     w_step;
  logic [4*N_DIGITS-1:0] w_next;
  logic [4*N_DIGITS-1:0] w_load_clean;
  logic [N_DIGITS-1:0]   w_load_bad;
  logic                  w_boundary;

  // Digit 0 always steps; w_step[N_DIGITS] is set only when every digit sits at the boundary.
  assign w_step[0] = 1'b1;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_digit
    bcd_digit_step u_step (
      .i_digit      (r_bcd[4*g +: 4]),
      .i_step_in    (w_step[g]),
      .i_up_down    (i_up_down),
      .o_next_digit (w_next[4*g +: 4]),
      .o_step_out   (w_step[g+1])
    );

    assign w_load_bad[g]           = ~is_valid_bcd(i_load_val[4*g +: 4]);
    assign w_load_clean[4*g +: 4]  = w_load_bad[g] ? BCD_MIN : i_load_val[4*g +: 4];
  end

  assign w_boundary = w_step[N_DIGITS];
  assign o_tc       = i_count_en & ~i_load & w_boundary;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bcd      <= RST_BCD;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else if (i_load) begin
      r_bcd      <= w_load_clean;
      r_wrap     <= 1'b0;
      r_load_err <= |w_load_bad;
    end else if (i_count_en) begin
`ifdef BCD_UPDOWN_COUNTER_N_SATURATE_EN
      r_bcd      <= w_boundary ? r_bcd : w_next;
`else
      r_bcd      <= w_next;
`endif
      r_wrap     <= w_boundary;
      r_load_err <= 1'b0;
    end else begin
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign o_bcd_out  = r_bcd;
  assign o_wrap     = r_wrap;
  assign o_load_err = r_load_err;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed self-checking bench for bcd_updown_counter_n with N_DIGITS=3, RST_VAL=0.
module tb_bcd_updown_counter_n;

  logic        clk;
  logic        rst;
  logic        count_en;
  logic        up_down;
  logic        load;
  logic [11:0] load_val;
  logic [11:0] bcd_out;
  logic        tc;
  logic        wrap;
  logic        load_err;

  int n_checks = 0;
  int n_pass   = 0;

  bcd_updown_counter_n #(.N_DIGITS(3), .RST_VAL(0)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_count_en (count_en),
    .i_up_down  (up_down),
    .i_load     (load),
    .i_load_val (load_val),
    .o_bcd_out  (bcd_out),
    .o_tc       (tc),
    .o_wrap     (wrap),
    .o_load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef BCD_UPDOWN_COUNTER_N_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] dec2bcd(input int v);
    logic [11:0] r;
    r[3:0]  = 4'((v % 10));
    r[7:4]  = 4'(((v / 10) % 10));
    r[11:8] = 4'(((v / 100) % 10));
    return r;
  endfunction

  initial begin
    int model;
    int wraps;
    rst = 1'b1; count_en = 1'b0; up_down = 1'b1; load = 1'b0; load_val = 12'h000;
    #3;
    chk("reset_bcd", bcd_out, 12'h000);
    chk("reset_wrap", wrap, 1'b0);
    chk("reset_err", load_err, 1'b0);
    #4 rst = 1'b0;

    // async reset in the middle of counting
    load = 1'b1; load_val = 12'h457;
    tick();
    load = 1'b0;
    chk("load_457", bcd_out, 12'h457);
    count_en = 1'b1; up_down = 1'b1;
    tick();
    chk("up_458", bcd_out, 12'h458);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_bcd", bcd_out, 12'h000);
    chk("async_rst_wrap", wrap, 1'b0);
    chk("async_rst_err", load_err, 1'b0);
    #2 rst = 1'b0;
    tick();
    chk("first_after_rst", bcd_out, 12'h001);

    // up carry chain
    count_en = 1'b0; load = 1'b1; load_val = 12'h099;
    tick();
    load = 1'b0; count_en = 1'b1; up_down = 1'b1;
    #1;
    chk("tc_099_up", tc, 1'b0);
    tick();
    chk("carry_100", bcd_out, 12'h100);
    count_en = 1'b0; load = 1'b1; load_val = 12'h999;
    tick();
    load = 1'b0; count_en = 1'b1; up_down = 1'b1;
    #1;
    chk("tc_999_up", tc, 1'b1);
    tick();
    chk("wrap_up_bcd", bcd_out, SAT ? 12'h999 : 12'h000);
    chk("wrap_up_pulse", wrap, 1'b1);
    count_en = 1'b0;
    #1;
    chk("tc_idle", tc, 1'b0);
    tick();
    chk("wrap_up_clear", wrap, 1'b0);

    // down borrow chain
    load = 1'b1; load_val = 12'h100;
    tick();
    load = 1'b0; count_en = 1'b1; up_down = 1'b0;
    tick();
    chk("borrow_099", bcd_out, 12'h099);
    chk("borrow_nowrap", wrap, 1'b0);
    count_en = 1'b0; load = 1'b1; load_val = 12'h000;
    tick();
    load = 1'b0; count_en = 1'b1; up_down = 1'b0;
    #1;
    chk("tc_000_down", tc, 1'b1);
    tick();
    chk("wrap_down_bcd", bcd_out, SAT ? 12'h000 : 12'h999);
    chk("wrap_down_pulse", wrap, 1'b1);
    count_en = 1'b0;
    tick();
    chk("wrap_down_clear", wrap, 1'b0);

    // load priority and validity
    count_en = 1'b1; up_down = 1'b1; load = 1'b1; load_val = 12'h5A3;
    #1;
    chk("tc_masked_by_load", tc, 1'b0);
    tick();
    chk("load_5A3", bcd_out, 12'h503);
    chk("load_5A3_err", load_err, 1'b1);
    chk("load_5A3_wrap", wrap, 1'b0);
    load = 1'b0; count_en = 1'b0;
    tick();
    chk("err_clear", load_err, 1'b0);
    chk("hold_503", bcd_out, 12'h503);
    load = 1'b1; load_val = 12'h7F9;
    tick();
    chk("load_7F9", bcd_out, 12'h709);
    chk("load_7F9_err", load_err, 1'b1);
    load_val = 12'h246;
    tick();
    chk("load_valid", bcd_out, 12'h246);
    chk("load_valid_err", load_err, 1'b0);
    load_val = 12'hFFF;
    tick();
    chk("load_FFF", bcd_out, 12'h000);
    chk("load_FFF_err", load_err, 1'b1);

    // direction toggle and hold
    load_val = 12'h010;
    tick();
    load = 1'b0; count_en = 1'b1;
    up_down = 1'b1; tick(); chk("toggle_1", bcd_out, 12'h011);
    up_down = 1'b0; tick(); chk("toggle_2", bcd_out, 12'h010);
    up_down = 1'b1; tick(); chk("toggle_3", bcd_out, 12'h011);
    up_down = 1'b0; tick(); chk("toggle_4", bcd_out, 12'h010);
    count_en = 1'b0; up_down = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_bcd", bcd_out, 12'h010);
      chk("hold_tc", tc, 1'b0);
      chk("hold_wrap", wrap, 1'b0);
    end

    // full-range sweep
    load = 1'b1; load_val = 12'h000;
    tick();
    load = 1'b0; count_en = 1'b1; up_down = 1'b1;
    model = 0;
    wraps = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (model == 999) model = SAT ? 999 : 0;
      else              model = model + 1;
      if (wrap) wraps++;
      chk("sweep_bcd", bcd_out, dec2bcd(model));
      chk("sweep_digits_valid",
          (bcd_out[3:0] <= 4'd9) && (bcd_out[7:4] <= 4'd9) && (bcd_out[11:8] <= 4'd9), 1'b1);
    end
    chk("sweep_end", bcd_out, SAT ? 12'h999 : 12'h000);
    chk("sweep_wrap_count", wraps, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit BCD up/down counter: N_DIGITS cascaded decimal digits, each 0..9, counting as one decimal number 0..(10^N_DIGITS - 1).
- Adds the following to the single-digit counter:
  - count enable
  - synchronous parallel load with BCD validity checking
  - terminal-count output for cascading further counters
  - registered wrap/error flags
- Sits in the counter/display path and feeds digit decoders or downstream cascade stages.

Parameters:
- N_DIGITS, 4: number of BCD digits (>=1); counter range 0 .. 10^N_DIGITS-1.
- RST_VAL, 0: decimal reset value, encoded as BCD at elaboration. It must be < 10^N_DIGITS; otherwise elaboration fails.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset; single clock domain.
- count_en  in  1  advance the counter one step this cycle.
- up_down  in  1  1 = count up, 0 = count down; sampled only when count_en=1.
- load  in  1  synchronous parallel load.
- load_val  in  4*N_DIGITS  BCD value to load; digit 0 is in bits [3:0].
- bcd_out  out  4*N_DIGITS  registered count; digit 0 is the least significant.
- tc  out  1  combinational terminal count, used as a cascade carry/borrow.
- wrap  out  1  registered, one-cycle pulse after a wrap or saturation event.
- load_err  out  1  registered, one-cycle pulse after a load containing an invalid digit.

Behaviour:
- Reset (async, rst=1):
  - bcd_out = BCD(RST_VAL), wrap=0, load_err=0.
  - Applies immediately and holds while rst is high; overrides any operation in flight.
  - First count occurs on the first rising edge after rst deasserts.
- Priority each cycle: load > count_en > hold.
- Load (load=1):
  - bcd_out <= load_val, one cycle latency; count_en is ignored that cycle.
  - Any nibble > 9 is loaded as 0 and load_err=1 next cycle. Valid nibbles load unchanged.
  - wrap=0 on that cycle.
- Count up (count_en=1, up_down=1, load=0):
  - Digit 0 increments.
  - Digit i (i>0) steps only when digits 0..i-1 all equal 9.
  - A stepping digit at 9 goes to 0; otherwise it goes to digit+1.
  - All carry resolution is combinational; the full result is registered in one cycle.
- Count down: mirror of count up.
  - Digit i steps only when digits 0..i-1 all equal 0.
  - A stepping digit at 0 goes to 9; otherwise it goes to digit-1.
- Hold (count_en=0, load=0): bcd_out unchanged; wrap=0, load_err=0.
- tc = count_en & ~load & (up_down ? all digits==9 : all digits==0).
  - Valid in the same cycle; drive the next stage's count_en with it.
- Wrap:
  - Up from all-9s gives all-0s, and wrap=1 for one cycle.
  - Down from all-0s gives all-9s, and wrap=1 for one cycle.
  - wrap always equals the registered value of tc.
- up_down may change every cycle; the direction takes effect on the same edge. There is no pipeline.
- bcd_out digits never hold a value > 9 under any input sequence.

Optional Feature:
- Macro: BCD_UPDOWN_COUNTER_N_SATURATE_EN.
- Defined: no wrap-around.
  - Count up at all-9s holds all-9s; count down at all-0s holds all-0s.
  - wrap pulses for one cycle on each such blocked step.
  - tc is unchanged, so cascaded stages still see the boundary.
- Undefined: modular wrap as described under Behaviour.

Decomposition:
- Package bcd_cnt_pkg holds:
  - constants BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0
  - typedef bcd_digit_t (logic [3:0])
  - function is_valid_bcd()
  - function to_bcd(int, n), used for RST_VAL encoding
- Sub-module bcd_digit_step: combinational, one per digit.
  - Inputs: digit, step_in, up_down.
  - Outputs: next_digit, step_out (digit at boundary & step_in).
  - Instantiated N_DIGITS times in a generate loop.
- Top level holds the registers, load mux, validity check and flags.

Test Plan (N_DIGITS=3, RST_VAL=0):
- Reset/async: assert rst mid-count at 0x457 between clock edges -> bcd_out=0x000 immediately, wrap=0, load_err=0; first edge after release with count_en=1, up=1 -> 0x001.
- Up carry chain: load 0x099, then count up 1 cycle -> 0x100, tc=0. Load 0x999, count up -> tc=1 in the load+1 cycle, then bcd_out=0x000 and wrap=1 for exactly one cycle.
- Down borrow chain: load 0x100, count down -> 0x099. From 0x000 count down -> tc=1, then 0x999 and wrap=1; with BCD_UPDOWN_COUNTER_N_SATURATE_EN -> stays 0x000 and wrap=1.
- Load priority/validity:
  - load=1 with count_en=1 and load_val=0x5A3 -> bcd_out=0x503, load_err=1 for one cycle.
  - load_val=0x7F9 -> 0x709.
- Direction toggle/hold: from 0x010 alternate up/down every cycle for 4 cycles -> 0x011, 0x010, 0x011, 0x010. count_en=0 for 5 cycles -> value held, tc=0.
- Full-range sweep: 1000 up steps from 0x000 -> returns to 0x000, exactly one wrap pulse, and every digit <= 9 on every cycle (assertion).
